crc_serial_param: RTL and testbench

// - Parametrised bit-serial systematic CRC encoder; successor to the fixed 16-bit serial CRC block.
// - Generic CRC_W/POLY/INIT/XOROUT; qualified input (in_valid); data echoed on crc_out, then CRC appended MSB-first.
// - Sits between a serial frame source and the line/serializer. Optional receive-side residue check.

---
 rtl/crc_serial_param.sv | 126 ++++++++++++
 tb/tb_crc_serial_param.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crc_serial_param.sv
// rtl/crc_serial_param.sv - parametrised bit-serial MSB-first CRC encoder with data echo and CRC append
// Optional receive-side residue check (crc_ok) enabled by defining CRC_CHECK_EN.
module crc_serial_param #(
    parameter int               CRC_W  = 16,
    parameter logic [CRC_W-1:0] POLY   = CRC_W'(16'h1021),
    parameter logic [CRC_W-1:0] INIT   = CRC_W'(16'hFFFF),
    parameter logic [CRC_W-1:0] XOROUT = CRC_W'(16'h0000)
`ifdef CRC_CHECK_EN
    ,
    parameter logic [CRC_W-1:0] RESIDUE = CRC_W'(16'h0000)
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             in_valid,
    input  logic             crc_in,
    input  logic             d_finish,
    output logic             crc_out,
    output logic             out_valid,
    output logic             busy,
    output logic             done,
    output logic [CRC_W-1:0] crc_val
`ifdef CRC_CHECK_EN
    ,
    output logic             crc_ok
`endif
);

    localparam int CNT_W = $clog2(CRC_W) + 1;

    typedef enum logic [1:0] {IDLE, SHIFT, FLUSH} state_t;

    state_t           state, state_next;
    logic [CRC_W-1:0] crc_reg, crc_upd, sreg;
    logic [CNT_W-1:0] cnt;
    logic             fb, last_bit;

    // Register value after absorbing this cycle's bit (if any)
    always_comb begin
        fb      = crc_reg[CRC_W-1] ^ crc_in;
        crc_upd = crc_reg;
        if (in_valid) begin
            crc_upd = {crc_reg[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
        end
    end

    assign last_bit = (cnt == CNT_W'(CRC_W - 1));

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (load) state_next = SHIFT;
            SHIFT:   if (!load && d_finish) state_next = FLUSH;
            FLUSH:   if (last_bit) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            crc_reg   <= INIT;
            sreg      <= '0;
            cnt       <= '0;
            crc_out   <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            crc_val   <= '0;
        end else begin
            state <= state_next;
            // busy stays up through the cycle that carries the last CRC bit
            busy  <= (state_next != IDLE) || (state == FLUSH);
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    crc_out   <= 1'b0;
                    out_valid <= 1'b0;
                    if (load) crc_reg <= INIT;
                end
                SHIFT: begin
                    if (load) begin
                        crc_reg   <= INIT;
                        crc_out   <= 1'b0;
                        out_valid <= 1'b0;
                    end else begin
                        crc_reg   <= crc_upd;
                        crc_out   <= in_valid & crc_in;
                        out_valid <= in_valid;
                        if (d_finish) begin
                            sreg    <= crc_upd ^ XOROUT;
                            crc_val <= crc_upd ^ XOROUT;
                            cnt     <= '0;
                        end
                    end
                end
                FLUSH: begin
                    crc_out   <= sreg[CRC_W-1];
                    sreg      <= {sreg[CRC_W-2:0], 1'b0};
                    out_valid <= 1'b1;
                    done      <= last_bit;
                    cnt       <= last_bit ? '0 : cnt + CNT_W'(1);
                end
                default: begin
                    crc_out   <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef CRC_CHECK_EN
    // Compared before XOROUT so a frame carrying its own CRC lands on the fixed residue
    always_ff @(posedge clk) begin
        if (!rst) begin
            crc_ok <= 1'b0;
        end else if (load && state != FLUSH) begin
            crc_ok <= 1'b0;
        end else if (state == SHIFT && d_finish) begin
            crc_ok <= (crc_upd == RESIDUE);
        end
    end
`endif

endmodule

// File: tb/tb_crc_serial_param.sv
// tb/tb_crc_serial_param.sv - randomized self-checking bench for crc_serial_param (16-bit default and 8-bit instance)
module tb_crc_serial_param;
    typedef bit bq_t[$];

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic load = 1'b0;
    logic in_valid = 1'b0;
    logic crc_in = 1'b0;
    logic d_finish = 1'b0;
    logic a_out, a_ov, a_busy, a_done;
    logic [15:0] a_val;
    logic b_out, b_ov, b_busy, b_done;
    logic [7:0] b_val;
`ifdef CRC_CHECK_EN
    logic a_ok, b_ok;
`endif

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int          w_t[2]    = '{16, 8};
    logic [31:0] poly_t[2] = '{32'h1021, 32'h07};
    logic [31:0] init_t[2] = '{32'hFFFF, 32'h0};
    logic [31:0] xor_t[2]  = '{32'h0, 32'h0};

    logic so[2], ov[2], bz[2], dn[2];
    logic [15:0] val[2];
    bit obs_q[2][$];
    int done_n[2] = '{0, 0};
    int done_cyc[2];
    int done_len[2];
    logic busy_at_done[2];
    logic busy_after[2];
    logic prev_dn[2] = '{1'b0, 1'b0};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign so[0] = a_out;  assign so[1] = b_out;
    assign ov[0] = a_ov;   assign ov[1] = b_ov;
    assign bz[0] = a_busy; assign bz[1] = b_busy;
    assign dn[0] = a_done; assign dn[1] = b_done;
    assign val[0] = a_val; assign val[1] = {8'h00, b_val};

    crc_serial_param dut_a (
        .clk(clk), .rst(rst), .load(load), .in_valid(in_valid), .crc_in(crc_in), .d_finish(d_finish),
        .crc_out(a_out), .out_valid(a_ov), .busy(a_busy), .done(a_done), .crc_val(a_val)
`ifdef CRC_CHECK_EN
        , .crc_ok(a_ok)
`endif
    );

    crc_serial_param #(.CRC_W(8), .POLY(8'h07), .INIT(8'h00), .XOROUT(8'h00)) dut_b (
        .clk(clk), .rst(rst), .load(load), .in_valid(in_valid), .crc_in(crc_in), .d_finish(d_finish),
        .crc_out(b_out), .out_valid(b_ov), .busy(b_busy), .done(b_done), .crc_val(b_val)
`ifdef CRC_CHECK_EN
        , .crc_ok(b_ok)
`endif
    );

    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (ov[u]) obs_q[u].push_back(so[u]);
            if (dn[u]) begin
                done_n[u]       <= done_n[u] + 1;
                done_cyc[u]     <= cyc;
                done_len[u]     <= obs_q[u].size();
                busy_at_done[u] <= bz[u];
            end
            if (prev_dn[u]) busy_after[u] <= bz[u];
            prev_dn[u] <= dn[u];
        end
    end

    // Remainder of (INIT*x^L + M(x)*x^W) mod G(x) by polynomial long division
    function automatic logic [31:0] model_rem(input int w, input logic [31:0] poly,
                                              input logic [31:0] init, input bq_t data);
        bit d[];
        bit g[];
        logic [31:0] r;
        int len;
        len = data.size();
        d = new[len + w];
        g = new[w + 1];
        for (int i = 0; i < len + w; i++) d[i] = (i < len) ? data[i] : 1'b0;
        for (int k = 0; k < w; k++) d[k] ^= init[w-1-k];
        g[0] = 1'b1;
        for (int m = 0; m < w; m++) g[m+1] = poly[w-1-m];
        for (int j = 0; j < len; j++)
            if (d[j]) for (int m = 0; m <= w; m++) d[j+m] ^= g[m];
        r = '0;
        for (int k = 0; k < w; k++) r[w-1-k] = d[len+k];
        return r;
    endfunction

    function automatic bq_t ascii_bits(input string s);
        bq_t q;
        byte c;
        for (int i = 0; i < s.len(); i++) begin
            c = s[i];
            for (int b = 7; b >= 0; b--) q.push_back(c[b]);
        end
        return q;
    endfunction

    task automatic run_frame(input string name, input bq_t data, input bit pre_abort);
        int st[2];
        int dn0[2];
        int c_fin;
        int len;
        int bad;
        logic [15:0] exp_val;
        bq_t exp_q;
        len = data.size();
        if (pre_abort) begin
            load = 1'b1; @(posedge clk); #1; load = 1'b0;
            for (int i = 0; i < 20; i++) begin
                in_valid = 1'b1; crc_in = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
            end
            in_valid = 1'b0;
        end
        load = 1'b1; @(posedge clk); #1; load = 1'b0;
        for (int u = 0; u < 2; u++) begin st[u] = obs_q[u].size(); dn0[u] = done_n[u]; end
        c_fin = 0;
        if (len == 0) begin
            d_finish = 1'b1; c_fin = cyc; @(posedge clk); #1;
        end else begin
            for (int i = 0; i < len; i++) begin
                while ($urandom_range(0, 3) == 0) begin in_valid = 1'b0; @(posedge clk); #1; end
                in_valid = 1'b1; crc_in = data[i]; d_finish = (i == len - 1);
                if (i == len - 1) c_fin = cyc;
                @(posedge clk); #1;
            end
        end
        in_valid = 1'b0; d_finish = 1'b0;
        repeat (20) @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            exp_val = 16'(model_rem(w_t[u], poly_t[u], init_t[u], data) ^ xor_t[u]);
            exp_q = data;
            for (int k = w_t[u] - 1; k >= 0; k--) exp_q.push_back(exp_val[k]);
            checks++;
            if (done_n[u] - dn0[u] !== 1) begin
                errors++; $display("FAIL %s u%0d done_count got %0d want 1", name, u, done_n[u] - dn0[u]);
            end
            checks++;
            if (done_cyc[u] !== c_fin + 1 + w_t[u]) begin
                errors++; $display("FAIL %s u%0d done_cycle got %0d want %0d", name, u, done_cyc[u], c_fin + 1 + w_t[u]);
            end
            checks++;
            if (done_len[u] - st[u] !== len + w_t[u]) begin
                errors++; $display("FAIL %s u%0d bits_at_done got %0d want %0d", name, u, done_len[u] - st[u], len + w_t[u]);
            end
            checks++;
            if (busy_at_done[u] !== 1'b1 || busy_after[u] !== 1'b0) begin
                errors++; $display("FAIL %s u%0d busy_edges got %b/%b want 1/0", name, u, busy_at_done[u], busy_after[u]);
            end
            checks++;
            if (val[u] !== exp_val) begin
                errors++; $display("FAIL %s u%0d crc_val got %h want %h", name, u, val[u], exp_val);
            end
            checks++;
            if (obs_q[u].size() - st[u] !== exp_q.size()) begin
                errors++; $display("FAIL %s u%0d stream_len got %0d want %0d", name, u, obs_q[u].size() - st[u], exp_q.size());
            end else begin
                bad = 0;
                for (int i = 0; i < exp_q.size(); i++) if (obs_q[u][st[u] + i] !== exp_q[i]) bad++;
                if (bad != 0) begin
                    errors++; $display("FAIL %s u%0d stream_bits got %0d wrong want 0 wrong", name, u, bad);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int u = 0; u < 2; u++) begin
            checks++;
            if ({so[u], ov[u], bz[u], dn[u]} !== 4'b0000 || val[u] !== 16'h0) begin
                errors++; $display("FAIL reset u%0d out/ov/busy/done got %b%b%b%b val %h want 0000 0", u, so[u], ov[u], bz[u], dn[u], val[u]);
            end
        end
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_check_value();
        run_frame("check_value", ascii_bits("123456789"), 1'b0);
        checks++;
        if (a_val !== 16'h29B1) begin errors++; $display("FAIL check_value a got %h want 29b1", a_val); end
        checks++;
        if (b_val !== 8'hF4) begin errors++; $display("FAIL check_value b got %h want f4", b_val); end
    endtask

    task automatic test_zero_length();
        bq_t empty;
        run_frame("zero_length", empty, 1'b0);
        checks++;
        if (a_val !== 16'hFFFF) begin errors++; $display("FAIL zero_length a got %h want ffff", a_val); end
        checks++;
        if (b_val !== 8'h00) begin errors++; $display("FAIL zero_length b got %h want 00", b_val); end
    endtask

    task automatic test_abort();
        run_frame("abort", ascii_bits("123456789"), 1'b1);
        checks++;
        if (a_val !== 16'h29B1) begin errors++; $display("FAIL abort a got %h want 29b1", a_val); end
    endtask

    task automatic test_random();
        bq_t data;
        int len;
        for (int n = 0; n < 6; n++) begin
            data.delete();
            len = $urandom_range(1, 40);
            for (int i = 0; i < len; i++) data.push_back(1'($urandom_range(0, 1)));
            run_frame("random", data, n == 3);
        end
    endtask

    task automatic test_reset_flush();
        int st;
        int dn0[2];
        int k;
        load = 1'b1; @(posedge clk); #1; load = 1'b0;
        st = obs_q[0].size();
        for (int u = 0; u < 2; u++) dn0[u] = done_n[u];
        for (int i = 0; i < 12; i++) begin
            in_valid = 1'b1; crc_in = 1'($urandom_range(0, 1)); d_finish = (i == 11);
            @(posedge clk); #1;
        end
        in_valid = 1'b0; d_finish = 1'b0;
        k = 0;
        while (obs_q[0].size() - st < 16 && k < 100) begin @(posedge clk); #1; k++; end
        checks++;
        if (k >= 100) begin errors++; $display("FAIL reset_flush wait got timeout want bit 5"); end
        rst = 1'b0; @(posedge clk); #1; rst = 1'b1;
        for (int u = 0; u < 2; u++) begin
            checks++;
            if (ov[u] !== 1'b0 || bz[u] !== 1'b0 || val[u] !== 16'h0) begin
                errors++; $display("FAIL reset_flush u%0d ov/busy/val got %b/%b/%h want 0/0/0", u, ov[u], bz[u], val[u]);
            end
        end
        repeat (20) @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            checks++;
            if (done_n[u] !== dn0[u]) begin
                errors++; $display("FAIL reset_flush u%0d done_pulses got %0d want 0", u, done_n[u] - dn0[u]);
            end
        end
        @(posedge clk); #1;
    endtask

`ifdef CRC_CHECK_EN
    task automatic test_residue();
        bq_t d;
        logic [15:0] c;
        logic exp_b;
        c = 16'h29B1;
        d = ascii_bits("123456789");
        for (int k = 15; k >= 0; k--) d.push_back(c[k]);
        run_frame("residue", d, 1'b0);
        exp_b = (model_rem(8, 32'h07, 32'h0, d) == 32'h0);
        checks++;
        if (a_ok !== 1'b1) begin errors++; $display("FAIL residue a crc_ok got %b want 1", a_ok); end
        checks++;
        if (b_ok !== exp_b) begin errors++; $display("FAIL residue b crc_ok got %b want %b", b_ok, exp_b); end
        d[5] = ~d[5];
        run_frame("residue_flip", d, 1'b0);
        checks++;
        if (a_ok !== 1'b0) begin errors++; $display("FAIL residue_flip a crc_ok got %b want 0", a_ok); end
    endtask
`endif

    initial begin
        test_reset();
        test_check_value();
        test_zero_length();
        test_abort();
        test_random();
        test_reset_flush();
`ifdef CRC_CHECK_EN
        test_residue();
`endif
        test_check_value();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
